// File: rtl/adpcm_block_unpacker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adpcm_block_unpacker
//
// Front end of the ADPCM decoder. It takes a byte stream of IMA-style ADPCM
// blocks, parses the 4-byte block header and emits the payload as 4-bit codes,
// one per handshake, low nibble first. The parsed header is presented with a
// one-cycle strobe so the decoder can be seeded before the block's first code.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset_n       synchronous active-low reset
//   in_data       input byte
//   in_valid      in_data valid
//   in_ready      byte accepted when in_valid && in_ready at a rising edge
//   code          ADPCM code to the decoder
//   code_valid    code holds a valid nibble
//   code_ready    consumer takes code when code_valid && code_ready
//   code_last     qualifies code: final nibble of the current block
//   hdr_sample    signed initial predictor (header bytes 0,1, little-endian)
//   hdr_index     initial step index (header byte 2), clamped to MAX_INDEX
//   hdr_valid     one-cycle strobe: hdr_sample/hdr_index updated
//   hdr_index_err one-cycle strobe with hdr_valid when raw index > MAX_INDEX
// -----------------------------------------------------------------------------
module adpcm_block_unpacker #(
    parameter int BLOCK_BYTES = 256,
    parameter int MAX_INDEX   = 88
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [3:0]         code,
    output logic               code_valid,
    input  logic               code_ready,
    output logic               code_last,
    output logic signed [15:0] hdr_sample,
    output logic [6:0]         hdr_index,
    output logic               hdr_valid,
    output logic               hdr_index_err
);

    localparam logic [15:0] DATA_BYTES = 16'(BLOCK_BYTES - 4);
    localparam logic [7:0]  MAX_IDX8   = 8'(MAX_INDEX);
    localparam logic [6:0]  MAX_IDX7   = 7'(MAX_INDEX);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_HDR3,
        S_DATA
    } state_t;

    // Which nibble of the buffered byte is currently presented on code.
    typedef enum logic [1:0] {
        P_EMPTY,
        P_LO,
        P_HI
    } ptr_t;

    state_t             state_q, state_d;
    ptr_t               ptr_q, ptr_d;
    logic [7:0]         buf_q, buf_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         b0_q, b0_d;
    logic [7:0]         b1_q, b1_d;
    logic [7:0]         b2_q, b2_d;
    logic signed [15:0] hdr_sample_d;
    logic [6:0]         hdr_index_d;
    logic               hdr_valid_d;
    logic               hdr_err_d;

    logic accept;
    logic take;
    logic last_byte;

    function automatic logic [6:0] clamp_index(input logic [7:0] raw);
        if (raw > MAX_IDX8) begin
            return MAX_IDX7;
        end
        return raw[6:0];
    endfunction

    // The counter only reaches DATA_BYTES once the final byte of the block has
    // been accepted, so while it sits there the buffer holds that final byte.
    assign last_byte  = (cnt_q == DATA_BYTES);

    assign code_valid = (ptr_q != P_EMPTY);
    assign code       = (ptr_q == P_HI) ? buf_q[7:4] : buf_q[3:0];
    assign code_last  = (ptr_q == P_HI) && last_byte;
    assign take       = code_valid && code_ready;
    assign accept     = in_valid && in_ready;

    // A new data byte may land in the same cycle the high nibble leaves, which
    // keeps a sustained one code per cycle with no bubble.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_HDR2, S_HDR3: in_ready = 1'b1;
            S_DATA: in_ready = !last_byte &&
                               ((ptr_q == P_EMPTY) || ((ptr_q == P_HI) && take));
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        b2_d         = b2_q;
        hdr_sample_d = hdr_sample;
        hdr_index_d  = hdr_index;
        hdr_valid_d  = 1'b0;
        hdr_err_d    = 1'b0;

        case (state_q)
            S_HDR0: begin
                if (accept) begin
                    b0_d    = in_data;
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    b1_d    = in_data;
                    state_d = S_HDR2;
                end
            end
            S_HDR2: begin
                if (accept) begin
                    b2_d    = in_data;
                    state_d = S_HDR3;
                end
            end
            S_HDR3: begin
                // Byte 3 is reserved; its arrival only completes the header.
                if (accept) begin
                    hdr_sample_d = {b1_q, b0_q};
                    hdr_index_d  = clamp_index(b2_q);
                    hdr_err_d    = (b2_q > MAX_IDX8);
                    hdr_valid_d  = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (take) begin
                    if (ptr_q == P_LO) begin
                        ptr_d = P_HI;
                    end else begin
                        ptr_d = P_EMPTY;
                        if (last_byte) begin
                            state_d = S_HDR0;
                        end
                    end
                end
                // in_ready guarantees the buffer is free (or freeing) here.
                if (accept) begin
                    buf_d = in_data;
                    ptr_d = P_LO;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_HDR0;
                ptr_d   = P_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_HDR0;
            ptr_q         <= P_EMPTY;
            buf_q         <= '0;
            cnt_q         <= '0;
            b0_q          <= '0;
            b1_q          <= '0;
            b2_q          <= '0;
            hdr_sample    <= '0;
            hdr_index     <= '0;
            hdr_valid     <= 1'b0;
            hdr_index_err <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            b0_q          <= b0_d;
            b1_q          <= b1_d;
            b2_q          <= b2_d;
            hdr_sample    <= hdr_sample_d;
            hdr_index     <= hdr_index_d;
            hdr_valid     <= hdr_valid_d;
            hdr_index_err <= hdr_err_d;
        end
    end

endmodule

// File: doc/adpcm_block_unpacker.md
Name: adpcm_block_unpacker

Overview:
Upstream stage of the ADPCM decoder. It accepts a byte stream of IMA-style ADPCM blocks, strips and parses the 4-byte block header, and emits 4-bit codes one per handshake, low nibble first, to feed the decoder's code input. The parsed header (initial predictor, step index) is presented with a one-cycle strobe so the decoder can be seeded at each block start.

Parameters:
BLOCK_BYTES, 256, total bytes per block including the 4-byte header; legal range 5..65535
MAX_INDEX, 88, highest legal step-table index; larger header indices are clamped

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
in_data  input  8  input byte
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted when in_valid && in_ready on a rising edge
code  output  4  ADPCM code to decoder
code_valid  output  1  code holds a valid nibble
code_ready  input  1  consumer takes code when code_valid && code_ready
code_last  output  1  qualifies code: final nibble of the current block
hdr_sample  output  16  signed initial predictor from header (little-endian bytes 0,1)
hdr_index  output  7  initial step index from header byte 2, clamped to MAX_INDEX
hdr_valid  output  1  one-cycle strobe: hdr_sample/hdr_index updated
hdr_index_err  output  1  one-cycle strobe with hdr_valid when raw index > MAX_INDEX

Behaviour:
- Reset (reset_n low at a rising edge, any state): state=HDR0, nibble buffer empty, byte counter=0, code_valid=0, code_last=0, hdr_valid=0, hdr_index_err=0, hdr_sample=0, hdr_index=0, code=0. in_ready is combinational and reads 1 in HDR0. Reset mid-block discards the partial block and the buffered byte.
- States: HDR0 (sample low byte), HDR1 (sample high byte), HDR2 (index), HDR3 (reserved byte, value ignored), DATA.
- Header states: in_ready=1. Each accepted byte advances one state. On acceptance in HDR3: hdr_sample={byte1,byte0}, hdr_index=min(byte2,MAX_INDEX), hdr_index_err=(byte2>MAX_INDEX), hdr_valid=1 registered for exactly the next cycle. State goes to DATA, data-byte counter=0.
- DATA: a one-byte buffer plus a nibble pointer (EMPTY, LO, HI).
  - in_ready = EMPTY, or HI with the current nibble being taken this cycle (code_valid && code_ready). This gives a sustained 1 nibble/cycle with no bubble.
  - Accepted byte is loaded into the buffer, pointer=LO, and code_valid=1 from the next cycle. code=byte[3:0] at LO and byte[7:4] at HI.
  - Handshake at LO moves the pointer to HI. Handshake at HI moves it to LO if a new byte is accepted the same cycle, else to EMPTY.
  - code and code_last are held stable while code_valid && !code_ready.
  - The data-byte counter increments on each accepted data byte. When BLOCK_BYTES-4 data bytes have been accepted, in_ready=0 until the last nibble is taken.
  - code_last=1 only on the HI nibble of byte BLOCK_BYTES-5 (0-based).
  - Handshake on that nibble: pointer=EMPTY, state=HDR0. The next block's header may be accepted in the following cycle.
- Header and data are never in flight together. hdr_valid always precedes the block's first code_valid by at least 1 cycle.
- Latency: byte accepted at edge N gives LO code valid from N+1. Header byte 3 accepted at N gives hdr_valid high during N+1.
- in_valid low: no state change. code_valid drops only after the buffered nibbles are consumed.

Test Plan:
- Reset, then header bytes 34 12 05 00 with in_valid held high -> hdr_valid one cycle, hdr_sample=0x1234, hdr_index=5, hdr_index_err=0; in_ready stays 1 through the 4 bytes.
- BLOCK_BYTES=6, header then data A7 3C, code_ready=1 -> codes 7,A,C,3 on consecutive cycles, code_last only on 3; next byte is parsed as HDR0.
- Header index byte 0x64 -> hdr_index=88, hdr_index_err strobes with hdr_valid.
- Data byte 5F with code_ready=0 for 3 cycles -> code=F held with code_valid=1 and in_ready=0; then code_ready=1 -> F, then 5.
- Continuous stream of 252 data bytes with code_ready=1 -> one code every cycle, no bubbles, exactly 504 codes, code_last on the 504th.
- reset_n low mid-DATA with a byte buffered -> next cycle code_valid=0, state HDR0; a fresh header parses correctly.
